// File: rtl/switch_move_encoder.sv
// Purpose : sync + debounce 16 board switches and emit a single-toggle move (cell index + direction).
// Latency : a toggle held from cycle 0 raises move_valid at cycle STABLE_CYCLES+4.
// Backpres: one move outstanding; move/idx/dir hold in PRESENT until move_ready, switches ignored meanwhile.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   sw           raw asynchronous switch inputs
//   move_ready   consumer accepts the presented move this cycle
//   move_valid   move_idx/move_dir hold a move
//   move_idx     index of the single toggled switch
//   move_dir     new level of the toggled switch (1 = on)
//   move_err     1-cycle pulse: settled pattern differed in 0 or >=2 bits
//   committed    last accepted switch pattern
//   busy         high whenever the FSM is not idle
// Build option: define SWITCH_REJECT_RESYNC_EN to adopt a rejected pattern
// after one cycle instead of waiting for the player to undo it.
module switch_move_encoder #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int CNTW          = 20,
  localparam int IDXW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [IDXW-1:0]  move_idx,
  output logic             move_dir,
  output logic             move_err,
  output logic [WIDTH-1:0] committed,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, PRESENT, REJECT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s1_q, ss_q;
  logic [WIDTH-1:0] committed_q, committed_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             move_valid_q, move_valid_d;
  logic             move_err_q, move_err_d;
  logic [IDXW-1:0]  move_idx_q, move_idx_d;
  logic             move_dir_q, move_dir_d;

  logic [WIDTH-1:0] diff;
  logic             one_hot;
  logic [IDXW-1:0]  idx_enc;

  // Synchroniser is left out of reset so that reset can snapshot the
  // current switch pattern into committed.
  always_ff @(posedge clk) begin
    s1_q <= sw;
    ss_q <= s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      committed_q  <= ss_q;
      cand_q       <= ss_q;
      cnt_q        <= '0;
      move_valid_q <= 1'b0;
      move_err_q   <= 1'b0;
      move_idx_q   <= '0;
      move_dir_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      committed_q  <= committed_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      move_valid_q <= move_valid_d;
      move_err_q   <= move_err_d;
      move_idx_q   <= move_idx_d;
      move_dir_q   <= move_dir_d;
    end
  end

  // With exactly one bit set the index is just the OR of the indices of the
  // set bits; no priority chain is needed.
  always_comb begin
    diff    = cand_q ^ committed_q;
    one_hot = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    idx_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i]) idx_enc = idx_enc | IDXW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    committed_d  = committed_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    move_valid_d = move_valid_q;
    move_err_d   = 1'b0;
    move_idx_d   = move_idx_q;
    move_dir_d   = move_dir_q;

    case (state_q)
      IDLE: begin
        if (ss_q != committed_q) begin
          cand_d  = ss_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (ss_q == committed_q) begin
          state_d = IDLE;            // bounced back, nothing to report
        end else if (ss_q != cand_q) begin
          cand_d = ss_q;             // still moving: restart the window
          cnt_d  = '0;
        end else if (cnt_q == CNTW'(STABLE_CYCLES - 1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      CHECK: begin
        if (one_hot) begin
          state_d      = PRESENT;
          move_valid_d = 1'b1;
          move_idx_d   = idx_enc;
          move_dir_d   = cand_q[idx_enc];
        end else begin
          state_d    = REJECT;
          move_err_d = 1'b1;
        end
      end
      PRESENT: begin
        if (move_ready) begin
          committed_d  = cand_q;
          move_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      REJECT: begin
`ifdef SWITCH_REJECT_RESYNC_EN
        committed_d = cand_q;        // adopt the multi-flip silently
        state_d     = IDLE;
`else
        if (ss_q == committed_q) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign move_valid = move_valid_q;
  assign move_idx   = move_idx_q;
  assign move_dir   = move_dir_q;
  assign move_err   = move_err_q;
  assign committed  = committed_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_switch_move_encoder.sv
// Purpose : directed self-checking bench for switch_move_encoder.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpres: move_ready driven directly by the sequence below.
module tb_switch_move_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = 16'h0000;
  logic        move_ready = 1'b0;
  logic        move_valid;
  logic [3:0]  move_idx;
  logic        move_dir;
  logic        move_err;
  logic [15:0] committed;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int vcnt, ecnt, bcnt;

  switch_move_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_idx  (move_idx),
    .move_dir  (move_dir),
    .move_err  (move_err),
    .committed (committed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Run n cycles, counting cycles with valid, err and busy high.
  task automatic watch(input int n, output int v, output int e, output int b);
    v = 0; e = 0; b = 0;
    repeat (n) begin
      step(1);
      if (move_valid === 1'b1) v++;
      if (move_err === 1'b1) e++;
      if (busy === 1'b1) b++;
    end
  endtask

  task automatic chk_move(input string tag, input logic [3:0] idx, input logic dir);
    chk({tag, "_valid"}, 32'(move_valid), 32'd1);
    chk({tag, "_idx"}, 32'(move_idx), 32'(idx));
    chk({tag, "_dir"}, 32'(move_dir), 32'(dir));
  endtask

  initial begin
    // Reset state
    step(4);
    reset = 1'b0;
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_err", 32'(move_err), 32'd0);
    chk("rst_idx", 32'(move_idx), 32'd0);
    chk("rst_dir", 32'(move_dir), 32'd0);
    chk("rst_committed", 32'(committed), 32'h0000);
    chk("rst_busy", 32'(busy), 32'd0);

    // ready while nothing is valid does nothing
    move_ready = 1'b1;
    step(2);
    move_ready = 1'b0;
    chk("idle_ready_valid", 32'(move_valid), 32'd0);
    chk("idle_ready_committed", 32'(committed), 32'h0000);

    // 1: bit 4 on, latency 8
    sw = 16'h0010;
    step(7);
    chk("t1_early_valid", 32'(move_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    step(1);
    chk_move("t1", 4'd4, 1'b1);
    chk("t1_precommit", 32'(committed), 32'h0000);
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    chk("t1_committed", 32'(committed), 32'h0010);
    chk("t1_drop_valid", 32'(move_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: bit 4 off, held under backpressure
    sw = 16'h0000;
    step(8);
    chk_move("t2", 4'd4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_move("t2_hold", 4'd4, 1'b0);
    end
    chk("t2_hold_committed", 32'(committed), 32'h0010);
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    chk("t2_committed", 32'(committed), 32'h0000);
    chk("t2_drop_valid", 32'(move_valid), 32'd0);

    // 3: short glitch on bit 7
    sw = 16'h0080;
    step(2);
    sw = 16'h0000;
    watch(12, vcnt, ecnt, bcnt);
    chk("t3_no_valid", 32'(vcnt), 32'd0);
    chk("t3_no_err", 32'(ecnt), 32'd0);
    chk("t3_was_busy", 32'(bcnt > 0), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_committed", 32'(committed), 32'h0000);

    // 4: two bits flipped together
    sw = 16'h8001;
    watch(12, vcnt, ecnt, bcnt);
    chk("t4_err_pulses", 32'(ecnt), 32'd1);
    chk("t4_no_valid", 32'(vcnt), 32'd0);
`ifdef SWITCH_REJECT_RESYNC_EN
    chk("t4_committed", 32'(committed), 32'h8001);
    chk("t4_busy", 32'(busy), 32'd0);
`else
    chk("t4_committed", 32'(committed), 32'h0000);
    chk("t4_busy_hold", 32'(busy), 32'd1);
    sw = 16'h0000;
    step(4);
    chk("t4_undo_busy", 32'(busy), 32'd0);
    chk("t4_undo_committed", 32'(committed), 32'h0000);
`endif
    sw = 16'h0000;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("t4_resync", 32'(committed), 32'h0000);

    // 5: reset in the middle of a presented move
    sw = 16'h0001;
    step(8);
    chk_move("t5", 4'd0, 1'b1);
    sw = 16'h0005;
    step(3);
    chk_move("t5_ignore", 4'd0, 1'b1);
    reset = 1'b1;
    step(1);
    chk("t5_rst_valid", 32'(move_valid), 32'd0);
    chk("t5_rst_committed", 32'(committed), 32'h0005);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step(2);
    chk("t5_after_busy", 32'(busy), 32'd0);
    sw = 16'h0000;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("t5_resync", 32'(committed), 32'h0000);

    // 6: bit 0 bouncing every 3 cycles, then settling high
    for (int k = 0; k < 4; k++) begin
      sw = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      watch(3, vcnt, ecnt, bcnt);
      chk("t6_bounce_valid", 32'(vcnt), 32'd0);
      chk("t6_bounce_err", 32'(ecnt), 32'd0);
    end
    sw = 16'h0001;
    step(7);
    chk("t6_early_valid", 32'(move_valid), 32'd0);
    step(1);
    chk_move("t6", 4'd0, 1'b1);
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    chk("t6_committed", 32'(committed), 32'h0001);

    // 7: top index, no wrap
    sw = 16'h8001;
    step(8);
    chk_move("t7", 4'd15, 1'b1);
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    chk("t7_committed", 32'(committed), 32'h8001);
    chk("t7_drop_valid", 32'(move_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
